pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Drives the PLL reset input and consumes its locked output, the opposite end of the PLL rst/locked interface.
- Pulses PLL reset, waits for lock, requires lock to stay stable, then releases the core's system reset.
- Retries on timeout or loss of lock, and latches a fail flag after too many retries.
- Runs on the 50 MHz reference clock, upstream of all core logic clocked by the PLL outputs.

Parameters:
- RST_PULSE_CYC, 16: width of the pll_rst pulse in clk cycles (min 1).
- LOCK_STABLE_CYC, 1024: consecutive cycles the synchronized lock must stay high before release (min 1).
- LOCK_TIMEOUT_CYC, 50000: maximum cycles spent waiting for lock per attempt (1 ms at 50 MHz).
- MAX_RETRIES, 7: failed attempts tolerated before FAIL; 0 means retry forever.
- CNT_W, 16: width of the internal cycle counter; must hold the largest cycle parameter.

Ports:
- clk, in, 1: 50 MHz reference clock; the block's only clock.
- rst, in, 1: asynchronous, active-high reset.
- locked_in, in, 1: PLL locked; asynchronous to clk, synchronized internally with 2 flops.
- force_relock, in, 1: one-cycle request to re-run the full sequence.
- pll_rst, out, 1: PLL reset, active high.
- sys_reset, out, 1: core reset, active high.
- ready, out, 1: high while in RUN.
- fail, out, 1: sticky failure flag.
- lock_lost, out, 1: one-cycle pulse when lock drops while in RUN.
- retry_count, out, 4: failed attempts since the last rst/force_relock; saturates at 15.

Behaviour:
- Reset values while rst is high: state=RESET_PLL, counter=0, pll_rst=1, sys_reset=1, ready=0, fail=0, lock_lost=0, retry_count=0. Sync flops=0.
- lock_s is locked_in after 2 clk flops, so there are 2 cycles of latency. All decisions use lock_s only.
- RESET_PLL:
  - pll_rst=1, sys_reset=1.
  - Counter runs 0..RST_PULSE_CYC-1, so pll_rst stays high exactly RST_PULSE_CYC cycles after entry.
  - Then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - pll_rst=0, sys_reset=1.
  - lock_s=1 -> STABILIZE, counter cleared.
  - Counter reaching LOCK_TIMEOUT_CYC-1 with lock_s=0 -> attempt fails (see failed attempt).
- STABILIZE:
  - pll_rst=0, sys_reset=1.
  - lock_s=0 at any point -> failed attempt.
  - LOCK_STABLE_CYC consecutive cycles of lock_s=1 -> RUN. sys_reset falls on the first RUN cycle.
- Failed attempt:
  - retry_count increments, saturating at 15.
  - If MAX_RETRIES!=0 and the new retry_count > MAX_RETRIES -> FAIL; otherwise -> RESET_PLL.
- RUN:
  - pll_rst=0, sys_reset=0, ready=1. retry_count is held.
  - lock_s falling -> lock_lost=1 for one cycle, then RESET_PLL. sys_reset reasserts in that same transition cycle, registered, so there is one cycle from the lock_s edge.
  - retry_count is NOT incremented for a lock loss in RUN.
- FAIL:
  - pll_rst=1 (PLL held in reset), sys_reset=1, fail=1.
  - Exits only via rst or force_relock.
- force_relock:
  - Takes effect in any state, taking precedence over every other transition in that cycle.
  - -> RESET_PLL with counter=0, retry_count=0, fail=0.
  - Also suppresses the lock_lost pulse if it coincides with a lock drop.
- sys_reset is never low unless state=RUN. ready == (state==RUN). All outputs are registered, so there are no combinational paths from inputs to outputs.
- Glitch rule: a lock_s pulse shorter than LOCK_STABLE_CYC during STABILIZE counts as a failed attempt; it is never treated as a lock.
- Asynchronous rst mid-sequence returns every output to its reset value immediately; no cycle ends with partial state.

Test Plan:
- Bring-up, with RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32:
  - Stimulus: release rst; raise locked_in 10 cycles later.
  - Required: pll_rst high exactly 4 cycles; sys_reset falls 2+8 cycles after locked_in rises (±1 for the entry cycle); ready=1; retry_count=0.
- Timeout retry:
  - Stimulus: hold locked_in=0 for 100 cycles.
  - Required: pll_rst re-pulses every 4+32 cycles; retry_count steps 1, 2; then lock is acquired -> RUN with retry_count=2.
- Fail path, with MAX_RETRIES=2:
  - Stimulus: locked_in never rises.
  - Required: after the 3rd timeout, fail=1, pll_rst=1, sys_reset=1, retry_count=3; outputs stay stable for 500 cycles.
  - Then pulse force_relock: fail=0, retry_count=0, sequence restarts.
- Stability glitch:
  - Stimulus: locked_in high 5 cycles, low 1, then high.
  - Required: no RUN entry; retry_count=1; second attempt reaches RUN.
- Lock loss in RUN:
  - Stimulus: drop locked_in.
  - Required: lock_lost pulses exactly one cycle, 3 cycles after the drop; sys_reset=1 in the same cycle; pll_rst pulses 4 cycles; retry_count unchanged.
- Async reset mid-STABILIZE:
  - Stimulus: assert rst for 1 ns off-edge.
  - Required: outputs go to their reset values immediately; a full sequence reruns after release.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, qualifies lock, releases the
// core reset, and retries on timeout or lock loss until a retry budget is spent.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int MAX_RETRIES      = 7,
    parameter int CNT_W            = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked_in,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYC - 1);

    logic             sync1_q;
    logic             lock_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d, retry_inc;
    logic             lost_d;
    logic             give_up;
    state_t           retry_target;
    logic             pll_rst_q, sys_reset_q, ready_q, fail_q, lock_lost_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= locked_in;
            lock_s_q <= sync1_q;
        end
    end

    assign retry_inc    = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
    assign give_up      = (MAX_RETRIES != 0) && (int'(retry_inc) > MAX_RETRIES);
    assign retry_target = give_up ? ST_FAIL : ST_RESET_PLL;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        lost_d  = 1'b0;
        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    retry_d = retry_inc;
                    state_d = retry_target;
                    cnt_d   = '0;
                end
            end
            ST_STABILIZE: begin
                if (!lock_s_q) begin
                    retry_d = retry_inc;
                    state_d = retry_target;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    lost_d  = 1'b1;
                    state_d = ST_RESET_PLL;
                end
            end
            ST_FAIL: cnt_d = '0;
            default: begin
                state_d = ST_RESET_PLL;
                cnt_d   = '0;
            end
        endcase
        // Relock overrides every transition above, including a coincident lock loss.
        if (force_relock) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
            lost_d  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
            sys_reset_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
            lock_lost_q <= lost_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign lock_lost   = lock_lost_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock/relock
// traffic, compared against a phase/elapsed-time model of the supervisor.
module tb_pll_lock_supervisor;

    localparam int RST_P  = 4;
    localparam int STAB_P = 8;
    localparam int TMO_P  = 32;
    localparam int MAXR_P = 2;

    logic       clk, rst, locked_in, force_relock;
    logic       pll_rst, sys_reset, ready, fail, lock_lost;
    logic [3:0] retry_count;
    logic [8:0] got;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (RST_P),
        .LOCK_STABLE_CYC (STAB_P),
        .LOCK_TIMEOUT_CYC(TMO_P),
        .MAX_RETRIES     (MAXR_P),
        .CNT_W           (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .locked_in   (locked_in),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .fail        (fail),
        .lock_lost   (lock_lost),
        .retry_count (retry_count)
    );

    assign got = {pll_rst, sys_reset, ready, fail, lock_lost, retry_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: phase plus time spent in it; lock seen through a 2-deep delay line.
    localparam int P_PULSE = 0, P_HUNT = 1, P_SETTLE = 2, P_RUN = 3, P_DEAD = 4;
    int   m_ph, m_since, m_retry;
    logic m_lost, m_s1, m_s2;

    always @(posedge clk or posedge rst) begin : ref_model
        int n, ph, r;
        logic lost;
        if (rst) begin
            m_ph <= P_PULSE; m_since <= 0; m_retry <= 0;
            m_lost <= 1'b0; m_s1 <= 1'b0; m_s2 <= 1'b0;
        end else begin
            n = m_since + 1; ph = m_ph; r = m_retry; lost = 1'b0;
            if (force_relock) begin
                ph = P_PULSE; r = 0;
            end else if ((m_ph == P_PULSE && n == RST_P)) begin
                ph = P_HUNT;
            end else if (m_ph == P_HUNT && m_s2) begin
                ph = P_SETTLE;
            end else if ((m_ph == P_HUNT && n == TMO_P) || (m_ph == P_SETTLE && !m_s2)) begin
                r  = (r < 15) ? r + 1 : 15;
                ph = (MAXR_P != 0 && r > MAXR_P) ? P_DEAD : P_PULSE;
            end else if (m_ph == P_SETTLE && n == STAB_P) begin
                ph = P_RUN;
            end else if (m_ph == P_RUN && !m_s2) begin
                ph = P_PULSE; lost = 1'b1;
            end
            m_s1    <= locked_in;
            m_s2    <= m_s1;
            m_lost  <= lost;
            m_retry <= r;
            m_ph    <= ph;
            m_since <= (ph != m_ph || force_relock) ? 0 : n;
        end
    end

    function automatic logic [8:0] model_out();
        return {(m_ph == P_PULSE) || (m_ph == P_DEAD), m_ph != P_RUN, m_ph == P_RUN,
                m_ph == P_DEAD, m_lost, m_retry[3:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; force_relock = 1'b0; locked_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; force_relock = 1'b0; locked_in = 1'b0;
        #1;
        checks++;
        if (got !== 9'b1_1_0_0_0_0000) begin
            errors++; $display("FAIL reset_immediate: got %b expected %b", got, 9'b110000000);
        end
        tick(); tick();
        checks++;
        if (got !== 9'b1_1_0_0_0_0000 || got !== model_out()) begin
            errors++; $display("FAIL reset_held: got %b expected %b", got, 9'b110000000);
        end
        rst = 1'b0;
    endtask

    task automatic test_bringup();
        int hi = 0, fall = -1;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            if (k == 10) locked_in = 1'b1;
            if (pll_rst) hi++;
            if (k >= 10 && !sys_reset && fall < 0) fall = k - 10;
            checks++;
            if (got !== model_out()) begin
                errors++; $display("FAIL bringup_model k=%0d: got %b expected %b", k, got, model_out());
            end
            tick();
        end
        checks++;
        if (hi != RST_P) begin
            errors++; $display("FAIL bringup_pll_rst_width: got %0d expected %0d", hi, RST_P);
        end
        checks++;
        if (fall < 2 + STAB_P - 1 || fall > 2 + STAB_P + 1) begin
            errors++; $display("FAIL bringup_release_delay: got %0d expected %0d..%0d", fall, 2 + STAB_P - 1, 2 + STAB_P + 1);
        end
        checks++;
        if (ready !== 1'b1 || retry_count !== 4'd0) begin
            errors++; $display("FAIL bringup_run: got ready=%b retry=%0d expected ready=1 retry=0", ready, retry_count);
        end
    endtask

    task automatic test_timeout_retry();
        int rises[$];
        logic prev;
        apply_reset();
        prev = pll_rst;
        for (int k = 0; k < 200; k++) begin
            if (k == 100) locked_in = 1'b1;
            if (!prev && pll_rst) rises.push_back(k);
            prev = pll_rst;
            if (k == RST_P + TMO_P || k == 2 * (RST_P + TMO_P)) begin
                checks++;
                if (retry_count !== 4'(k / (RST_P + TMO_P))) begin
                    errors++; $display("FAIL timeout_retry_step k=%0d: got %0d expected %0d", k, retry_count, k / (RST_P + TMO_P));
                end
            end
            checks++;
            if (got !== model_out()) begin
                errors++; $display("FAIL timeout_model k=%0d: got %b expected %b", k, got, model_out());
            end
            tick();
        end
        checks++;
        if (rises.size() != 2 || rises[0] != RST_P + TMO_P || rises[1] != 2 * (RST_P + TMO_P)) begin
            errors++; $display("FAIL timeout_repulse: got %0d rises first=%0d expected 2 rises at %0d,%0d",
                               rises.size(), (rises.size() > 0) ? rises[0] : -1, RST_P + TMO_P, 2 * (RST_P + TMO_P));
        end
        checks++;
        if (ready !== 1'b1 || retry_count !== 4'd2) begin
            errors++; $display("FAIL timeout_run: got ready=%b retry=%0d expected ready=1 retry=2", ready, retry_count);
        end
    endtask

    task automatic test_fail_path();
        int at = -1;
        logic bad = 1'b0;
        apply_reset();
        for (int k = 0; k < 300 && at < 0; k++) begin
            if (fail) at = k; else tick();
        end
        checks++;
        if (at != 3 * (RST_P + TMO_P)) begin
            errors++; $display("FAIL fail_entry_time: got %0d expected %0d", at, 3 * (RST_P + TMO_P));
        end
        checks++;
        if (got !== 9'b1_1_0_1_0_0011) begin
            errors++; $display("FAIL fail_outputs: got %b expected %b", got, 9'b110100011);
        end
        for (int k = 0; k < 500; k++) begin
            tick();
            if (got !== 9'b1_1_0_1_0_0011) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL fail_sticky: got %b expected %b", got, 9'b110100011);
        end
        force_relock = 1'b1; tick(); force_relock = 1'b0;
        checks++;
        if (got !== 9'b1_1_0_0_0_0000 || got !== model_out()) begin
            errors++; $display("FAIL relock_clear: got %b expected %b", got, 9'b110000000);
        end
        for (int k = 1; k < RST_P; k++) tick();
        checks++;
        if (pll_rst !== 1'b1) begin
            errors++; $display("FAIL relock_pulse_end: got %b expected 1", pll_rst);
        end
        tick();
        checks++;
        if (pll_rst !== 1'b0 || got !== model_out()) begin
            errors++; $display("FAIL relock_restart: got %b expected %b", got, model_out());
        end
    endtask

    task automatic test_glitch();
        logic early = 1'b0;
        apply_reset();
        for (int k = 0; k < 6; k++) tick();
        for (int k = 0; k < 80; k++) begin
            if (k == 0) locked_in = 1'b1;
            if (k == 5) locked_in = 1'b0;
            if (k == 6) locked_in = 1'b1;
            if (ready && retry_count == 4'd0) early = 1'b1;
            checks++;
            if (got !== model_out()) begin
                errors++; $display("FAIL glitch_model k=%0d: got %b expected %b", k, got, model_out());
            end
            tick();
        end
        checks++;
        if (early) begin
            errors++; $display("FAIL glitch_no_run: got early RUN expected none");
        end
        checks++;
        if (ready !== 1'b1 || retry_count !== 4'd1) begin
            errors++; $display("FAIL glitch_second_attempt: got ready=%b retry=%0d expected ready=1 retry=1", ready, retry_count);
        end
    endtask

    task automatic test_lock_loss();
        int lost_k = -1, pulses = 0, hi = 0;
        logic sr_ok = 1'b0, keep = 1'b1;
        locked_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (lock_lost) begin
                pulses++;
                if (lost_k < 0) lost_k = k;
                sr_ok = sys_reset;
            end
            if (pll_rst) hi++;
            if (retry_count !== 4'd1) keep = 1'b0;
        end
        checks++;
        if (lost_k != 3 || pulses != 1) begin
            errors++; $display("FAIL lock_lost_pulse: got at %0d width %0d expected at 3 width 1", lost_k, pulses);
        end
        checks++;
        if (sr_ok !== 1'b1) begin
            errors++; $display("FAIL lock_lost_sys_reset: got %b expected 1", sr_ok);
        end
        checks++;
        if (hi != RST_P) begin
            errors++; $display("FAIL lock_lost_repulse: got %0d expected %0d", hi, RST_P);
        end
        checks++;
        if (!keep) begin
            errors++; $display("FAIL lock_lost_retry_held: got %0d expected 1", retry_count);
        end
    endtask

    task automatic test_async_reset();
        int run_k = -1;
        apply_reset();
        locked_in = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        #2 rst = 1'b1;
        #0.5;
        checks++;
        if (got !== 9'b1_1_0_0_0_0000) begin
            errors++; $display("FAIL async_reset_outputs: got %b expected %b", got, 9'b110000000);
        end
        #0.5 rst = 1'b0;
        tick();
        for (int k = 0; k < 60 && run_k < 0; k++) begin
            checks++;
            if (got !== model_out()) begin
                errors++; $display("FAIL async_rerun_model k=%0d: got %b expected %b", k, got, model_out());
            end
            if (ready) run_k = k; else tick();
        end
        checks++;
        if (run_k < 0 || retry_count !== 4'd0) begin
            errors++; $display("FAIL async_rerun: got run_at=%0d retry=%0d expected RUN with retry 0", run_k, retry_count);
        end
    endtask

    task automatic test_random();
        int seg = 0, shown = 0;
        apply_reset();
        for (int k = 0; k < 4000; k++) begin
            if (seg == 0) begin
                locked_in = 1'($urandom_range(0, 1));
                seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 60));
            end
            seg--;
            force_relock = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (got !== model_out()) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_model k=%0d: got %b expected %b", k, got, model_out());
                end
            end
        end
        force_relock = 1'b0;
    endtask

    initial begin
        rst = 1'b0; locked_in = 1'b0; force_relock = 1'b0;
        #3;
        test_reset();
        test_bringup();
        test_timeout_retry();
        test_fail_path();
        test_glitch();
        test_lock_loss();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
